// File: rtl/da2_receiver_if.sv
// Signal bundle between a DA2-style serial master and the receiver.
// The master drives the serial lines, and the receiver returns the decoded frame.
interface da2_receiver_if;
   logic        SCLK;
   logic        SDATA;
   logic        SYNC;
   logic [1:0]  mode;
   logic [11:0] value;
   logic        valid;
   logic        frame_err;
   logic        busy;

   modport master (
      output SCLK, SDATA, SYNC,
      input  mode, value, valid, frame_err, busy
   );

   modport slave (
      input  SCLK, SDATA, SYNC,
      output mode, value, valid, frame_err, busy
   );
endinterface

// File: rtl/da2_receiver.sv
// DA2 serial receiver. It oversamples SCLK, SDATA and SYNC on clk and decodes
// 16-bit MSB-first frames into power-down mode bits and a 12-bit value.
module da2_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          rst,
   da2_receiver_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   // Each stage holds the bits {SYNC, SDATA, SCLK}, so all three lines share one delay.
   logic [2:0]  pipe_reg [SYNC_STAGES];
   logic        sclk_prev_reg;
   logic        sync_prev_reg;
   logic [2:0]  settle_reg;
   logic        arm_reg;

   state_t      state_reg, state_next;
   logic [15:0] sreg_reg, sreg_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic [1:0]  mode_reg, mode_next;
   logic [11:0] value_reg, value_next;
   logic        valid_reg, valid_next;
   logic        err_reg, err_next;

   logic [2:0]  sync_out;
   logic        sclk_s, sdata_s, sync_s;
   logic        sclk_fall, sync_fall, sync_rise, settle_done, arm_next;

   assign sync_out    = pipe_reg[SYNC_STAGES-1];
   assign sclk_s      = sync_out[0];
   assign sdata_s     = sync_out[1];
   assign sync_s      = sync_out[2];
   assign sclk_fall   = sclk_prev_reg & ~sclk_s;
   assign sync_fall   = sync_prev_reg & ~sync_s;
   assign sync_rise   = ~sync_prev_reg & sync_s;
   assign settle_done = (settle_reg == 3'(SYNC_STAGES));
   // Frames start only after SYNC is seen high on real data. The reset-time ones in
   // the synchronizer would otherwise create a false fall when SYNC is held low.
   assign arm_next    = arm_reg | (settle_done & sync_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) pipe_reg[i] <= 3'b101;
         sclk_prev_reg <= 1'b1;
         sync_prev_reg <= 1'b1;
         settle_reg    <= '0;
         arm_reg       <= 1'b0;
      end else begin
         pipe_reg[0] <= {bus.SYNC, bus.SDATA, bus.SCLK};
         for (int i = 1; i < SYNC_STAGES; i++) pipe_reg[i] <= pipe_reg[i-1];
         sclk_prev_reg <= sclk_s;
         sync_prev_reg <= sync_s;
         if (!settle_done) settle_reg <= settle_reg + 3'd1;
         arm_reg       <= arm_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sreg_next  = sreg_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;
      value_next = value_reg;
      valid_next = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (arm_reg && sync_fall) begin
               sreg_next  = '0;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_reg == 5'd16) begin
               mode_next  = sreg_reg[13:12];
               value_next = sreg_reg[11:0];
               valid_next = 1'b1;
               state_next = sync_rise ? IDLE : HOLD;
            end else if (sync_rise) begin
               // A SYNC rise beats an SCLK fall in the same cycle.
               err_next   = (cnt_reg != 5'd0);
               state_next = IDLE;
            end else if (sclk_fall) begin
               sreg_next  = {sreg_reg[14:0], sdata_s};
               cnt_next   = cnt_reg + 5'd1;
            end
         end
         HOLD: begin
            if (sync_rise) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sreg_reg  <= '0;
         cnt_reg   <= '0;
         mode_reg  <= '0;
         value_reg <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sreg_reg  <= sreg_next;
         cnt_reg   <= cnt_next;
         mode_reg  <= mode_next;
         value_reg <= value_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
      end
   end

   assign bus.mode      = mode_reg;
   assign bus.value     = value_reg;
   assign bus.valid     = valid_reg;
   assign bus.frame_err = err_reg;
   assign bus.busy      = (state_reg == SHIFT);
endmodule

// File: doc/da2_receiver.md
DA2_RECEIVER -- requirements
Module: da2_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of flip-flop stages on each of SCLK, SDATA and SYNC (legal values 2-4).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port SCLK  input  1  serial clock from the DA2 master; asynchronous to clk.
REQ-005 SHALL have port SDATA  input  1  serial data, MSB first, valid at SCLK falling edges.
REQ-006 SHALL have port SYNC  input  1  frame select, active-low; idle high.
REQ-007 SHALL have port mode  output  2  power-down mode bits (frame bits 13:12) of the last complete frame.
REQ-008 SHALL have port value  output  12  data bits (frame bits 11:0) of the last complete frame.
REQ-009 SHALL have port valid  output  1  one-clk pulse when mode/value update.
REQ-010 SHALL have port frame_err  output  1  one-clk pulse when a frame aborts after 1-15 bits.
REQ-011 SHALL have port busy  output  1  high while a frame is being received (state SHIFT).

Function
REQ-012 SHALL pass SCLK, SDATA and SYNC through identical SYNC_STAGES-deep synchronizers so that their relative timing is preserved.
REQ-013 SHALL detect SCLK falls as: synchronized SCLK high on the previous clk and low on the current clk; SYNC falls and rises are detected the same way.
REQ-014 SHALL support an SCLK high time and low time of at least SYNC_STAGES+1 clk periods each; behaviour with faster SCLK is undefined.
REQ-015 SHALL implement states IDLE, SHIFT and HOLD.
REQ-016 IDLE: a SYNC fall clears the 16-bit shift register and the 5-bit bit counter, and the next state is SHIFT.
REQ-017 IDLE: SCLK edges are ignored, and a SYNC level that is already low without a detected fall is ignored.
REQ-018 SHIFT: each SCLK fall shifts the synchronized SDATA into the shift register LSB (MSB-first frame) and increments the bit counter.
REQ-019 SHIFT: when the counter reaches 16, on the cycle after that 16th SCLK fall the block sets mode=sreg[13:12], sets value=sreg[11:0], pulses valid for exactly 1 clk, and moves to HOLD.
REQ-020 SHALL ignore frame bits 15:14.
REQ-021 SHIFT, SYNC rise with counter 1-15: frame_err pulses for 1 clk, mode/value stay unchanged, valid stays low, next state is IDLE.
REQ-022 SHIFT, SYNC rise with counter 0: return to IDLE silently, with no pulse.
REQ-023 SHIFT, SYNC rise and SCLK fall detected in the same clk: the SYNC rise wins and the SCLK edge is discarded.
REQ-024 HOLD: SCLK falls (bits 17+) are ignored, and a SYNC rise moves the state to IDLE.
REQ-025 HOLD: mode/value are never changed until the next complete frame.
REQ-026 busy SHALL be 1 exactly in state SHIFT.
REQ-027 valid and frame_err SHALL never be high in the same cycle.
REQ-028 Latency: valid SHALL rise no later than SYNC_STAGES+2 clk after the 16th SCLK falling edge at the pin.
REQ-029 Back-to-back frames: a new SYNC fall detected in the same clk as the entry to IDLE SHALL NOT be lost; it SHALL be accepted on the next clk if SYNC is still low at that point.

Reset
REQ-030 On rst=1 at a clk edge: state=IDLE; shift register=0; counter=0; mode=0; value=0; valid=0; frame_err=0; busy=0.
REQ-031 On rst=1 at a clk edge, all synchronizer and edge flops for SCLK and SYNC SHALL be set to 1 and those for SDATA to 0.
REQ-032 Reset mid-frame SHALL abort that frame with no valid and no frame_err pulse.
REQ-033 After reset release with SYNC already low, the frame in progress SHALL be ignored until SYNC rises and falls again.

Verification
REQ-034 SHALL test, at clk/25 SCLK, a frame 0x0ABC (mode 00) -> one valid pulse, value=12'hABC, mode=2'b00, frame_err never high.
REQ-035 SHALL test a frame 0x3FFF -> mode=2'b11, value=12'hFFF; then a frame 0x0000 -> mode=0, value=0, with two separate valid pulses.
REQ-036 SHALL test raising SYNC after 9 SCLK falls -> one frame_err pulse, valid low, value and mode keep their previous frame contents.
REQ-037 SHALL test a 20-SCLK frame with 0x1123 in the first 16 bits -> a single valid pulse after edge 16, value=12'h123, mode=2'b01, and edges 17-20 ignored.
REQ-038 SHALL test rst asserted after 8 bits with SYNC held low through reset release, followed by 8 more SCLKs and then SYNC high -> no valid, no frame_err, outputs 0; the next full frame 0x0555 gives value=12'h555.
REQ-039 SHALL test a SYNC pulse with no SCLK edges -> no valid and no frame_err; busy is high only between the SYNC fall and rise.
